// File: rtl/univ_shift_pkg.sv
// Shared encodings for the universal shift register: command modes and burst FSM states.
package univ_shift_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROTL = 3'b100;
   localparam logic [2:0] MODE_ROTR = 3'b101;
   localparam logic [2:0] MODE_TX   = 3'b110;
   localparam logic [2:0] MODE_RX   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_TX   = 2'b01,
      ST_RX   = 2'b10
   } state_e;

endpackage

// File: rtl/univ_shift_reg.sv
// Universal register: hold/load/shift/rotate plus self-timed serial transmit and receive bursts.
module univ_shift_reg
   import univ_shift_pkg::*;
#(
   parameter int unsigned          WIDTH     = 7,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam int unsigned          CntW    = (WIDTH < 2) ? 1 : $clog2(WIDTH);
   localparam logic [CntW-1:0]      CntLast = CntW'(WIDTH - 1);

   if (WIDTH < 2) begin : g_width_check
      $error("univ_shift_reg: WIDTH must be at least 2");
   end

   state_e          state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             done_q, done_d;

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (en) begin
               case (mode)
                  MODE_LOAD: q_d = d;
                  MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin};
                  MODE_SHR:  q_d = {sin, q_q[WIDTH-1:1]};
                  MODE_ROTL: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                  MODE_ROTR: q_d = {q_q[0], q_q[WIDTH-1:1]};
                  MODE_TX: begin
                     q_d     = d;
                     cnt_d   = '0;
                     state_d = ST_TX;
                  end
                  MODE_RX: begin
                     cnt_d   = '0;
                     state_d = ST_RX;
                  end
                  default: q_d = q_q;
               endcase
            end
         end
         ST_TX, ST_RX: begin
            // TX drains zeros in behind the outgoing LSB; RX fills from the top.
            q_d   = {(state_q == ST_RX) ? sin : 1'b0, q_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         q_q     <= RESET_VAL;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign q    = q_q;
   assign busy = (state_q != ST_IDLE);
   assign sout = (state_q == ST_TX) ? q_q[0] : 1'b0;
   assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed scoreboard bench for univ_shift_reg at WIDTH=7, RESET_VAL=0.
module tb_univ_shift_reg;
   import univ_shift_pkg::*;

   localparam int unsigned W = 7;

   logic         clk;
   logic         reset;
   logic         en;
   logic [2:0]   mode;
   logic [W-1:0] d;
   logic         sin;
   logic [W-1:0] q;
   logic         sout;
   logic         busy;
   logic         done;

   univ_shift_reg #(
      .WIDTH     (W),
      .RESET_VAL ('0)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .mode (mode),
      .d    (d),
      .sin  (sin),
      .q    (q),
      .sout (sout),
      .busy (busy),
      .done (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        tag;
      logic [W-1:0] q;
      logic         busy;
      logic         done;
      logic         sout;
   } exp_t;

   exp_t sb[$];
   int   n_run  = 0;
   int   n_fail = 0;

   task automatic drive(input logic r, input logic e, input logic [2:0] m,
                        input logic [W-1:0] dd, input logic s);
      reset = r;
      en    = e;
      mode  = m;
      d     = dd;
      sin   = s;
   endtask

   task automatic push_exp(input string tag, input logic [W-1:0] eq, input logic eb,
                           input logic ed, input logic es);
      exp_t e;
      e.tag  = tag;
      e.q    = eq;
      e.busy = eb;
      e.done = ed;
      e.sout = es;
      sb.push_back(e);
   endtask

   task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Advance one edge, then check all outputs against the oldest expectation.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_run++;
         n_fail++;
         $error("FAIL sb_empty: observed no expectation, expected one queued");
      end else begin
         e = sb.pop_front();
         cmp({e.tag, ".q"},    q,             e.q);
         cmp({e.tag, ".busy"}, W'(busy),      W'(e.busy));
         cmp({e.tag, ".done"}, W'(done),      W'(e.done));
         cmp({e.tag, ".sout"}, W'(sout),      W'(e.sout));
      end
   endtask

   logic [W-1:0] tx_d;
   logic [W-1:0] rx_bits;
   logic [W-1:0] rx_q;

   initial begin
      drive(1'b1, 1'b1, MODE_LOAD, 7'b1010101, 1'b0);

      // Reset wins over a pending load
      push_exp("rst0", 7'b0000000, 1'b0, 1'b0, 1'b0); tick();
      push_exp("rst1", 7'b0000000, 1'b0, 1'b0, 1'b0); tick();

      drive(1'b0, 1'b1, MODE_LOAD, 7'b0000111, 1'b0);
      push_exp("load", 7'b0000111, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b1, MODE_SHL, 7'b0, 1'b1);
      push_exp("shl", 7'b0001111, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b1, MODE_SHR, 7'b0, 1'b0);
      push_exp("shr", 7'b0000111, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b1, MODE_LOAD, 7'b1000001, 1'b0);
      push_exp("load2", 7'b1000001, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b1, MODE_ROTL, 7'b0, 1'b1);
      push_exp("rotl", 7'b0000011, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b1, MODE_ROTR, 7'b0, 1'b0);
      push_exp("rotr", 7'b1000001, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, MODE_LOAD, 7'b0101010, 1'b1);
      push_exp("en_off", 7'b1000001, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b1, MODE_HOLD, 7'b0101010, 1'b1);
      push_exp("hold", 7'b1000001, 1'b0, 1'b0, 1'b0); tick();

      // TX burst, LSB first; a load at k=3 must be ignored
      tx_d = 7'b1011001;
      drive(1'b0, 1'b1, MODE_TX, tx_d, 1'b0);
      for (int k = 0; k < 7; k++) begin
         push_exp($sformatf("tx%0d", k), tx_d >> k, 1'b1, 1'b0, tx_d[k]);
         tick();
         if (k == 2) drive(1'b0, 1'b1, MODE_LOAD, 7'b1111111, 1'b1);
         else        drive(1'b0, 1'b0, MODE_HOLD, 7'b0, 1'b0);
      end
      push_exp("tx_done", 7'b0000000, 1'b0, 1'b1, 1'b0); tick();
      push_exp("tx_post", 7'b0000000, 1'b0, 1'b0, 1'b0); tick();

      // Reset abort in the 3rd TX cycle
      drive(1'b0, 1'b1, MODE_TX, tx_d, 1'b0);
      push_exp("ab0", 7'b1011001, 1'b1, 1'b0, 1'b1); tick();
      drive(1'b0, 1'b0, MODE_HOLD, 7'b0, 1'b0);
      push_exp("ab1", 7'b0101100, 1'b1, 1'b0, 1'b0); tick();
      push_exp("ab2", 7'b0010110, 1'b1, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b0, MODE_HOLD, 7'b0, 1'b0);
      push_exp("ab_rst", 7'b0000000, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, MODE_HOLD, 7'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         push_exp($sformatf("ab_idle%0d", k), 7'b0000000, 1'b0, 1'b0, 1'b0);
         tick();
      end

      // RX burst: first sampled bit lands in q[0]
      rx_bits = 7'b1001011;
      rx_q    = 7'b0000000;
      drive(1'b0, 1'b1, MODE_RX, 7'b1111111, 1'b0);
      push_exp("rx_go", rx_q, 1'b1, 1'b0, 1'b0); tick();
      for (int k = 0; k < 7; k++) begin
         drive(1'b0, 1'b0, MODE_HOLD, 7'b0, rx_bits[k]);
         rx_q = {rx_bits[k], rx_q[W-1:1]};
         if (k < 6) push_exp($sformatf("rx%0d", k), rx_q, 1'b1, 1'b0, 1'b0);
         else       push_exp("rx_done", 7'b1001011, 1'b0, 1'b1, 1'b0);
         tick();
      end

      // Back-to-back: TX issued in the RX done cycle
      drive(1'b0, 1'b1, MODE_TX, 7'b1111111, 1'b0);
      for (int k = 0; k < 7; k++) begin
         push_exp($sformatf("b2b%0d", k), 7'b1111111 >> k, 1'b1, 1'b0, 1'b1);
         tick();
         drive(1'b0, 1'b0, MODE_HOLD, 7'b0, 1'b0);
      end
      push_exp("b2b_done", 7'b0000000, 1'b0, 1'b1, 1'b0); tick();
      push_exp("b2b_post", 7'b0000000, 1'b0, 1'b0, 1'b0); tick();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal register replacing the fixed 7-bit D register used in lab datapaths. It supports hold, parallel load, shift and rotate in both directions, and two self-timed serial burst modes: parallel-to-serial transmit and serial-to-parallel receive, each with busy and done status. It sits between lab I/O (switches, serial pins) and downstream datapath registers, running on the single system clock.

## Interface
- WIDTH, 7, register width in bits; must be ≥ 2.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  command strobe; mode is acted on only when en=1 and busy=0.
- mode  in  3  operation select (see Operation).
- d  in  WIDTH  parallel data for load and transmit.
- sin  in  1  serial input for shift and receive.
- q  out  WIDTH  register contents (registered).
- sout  out  1  serial transmit bit.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse after a burst completes.

## Operation
- The block has one clock and a synchronous, active-high reset. Reset, sampled at a clk edge, takes priority over everything. It sets q=RESET_VAL, state=IDLE, cnt=0, busy=0, done=0 and sout=0.
- State machine with states IDLE, TX and RX. cnt is $clog2(WIDTH) bits wide.
- In IDLE, at an edge with en=1, the block decodes mode:
  - 000 hold: q unchanged.
  - 001 load: q<=d.
  - 010 shl: q<={q[W-2:0],sin}.
  - 011 shr: q<={sin,q[W-1:1]}.
  - 100 rotl: q<={q[W-2:0],q[W-1]}.
  - 101 rotr: q<={q[0],q[W-1:1]}.
  - 110 tx: q<=d, cnt<=0, go to TX.
  - 111 rx: q unchanged, cnt<=0, go to RX.
- In IDLE with en=0, q holds regardless of mode.
- TX, each edge: q<={1'b0,q[W-1:1]}, cnt<=cnt+1. When cnt==WIDTH-1, go to IDLE and set done<=1. Bits go out LSB first. After the burst, q=0.
- RX, each edge: q<={sin,q[W-1:1]}, cnt<=cnt+1. When cnt==WIDTH-1, go to IDLE and set done<=1. The first sampled bit ends in q[0].
- While in TX or RX, en, mode and d are ignored. There is no queuing.
- Output definitions:
  - busy = (state != IDLE).
  - sout = q[0] in TX, otherwise 0.
  - done is registered and high for exactly one cycle.

## Timing
- Plain modes: q reflects the result one edge after acceptance (zero-wait, one-cycle latency).
- TX accepted at edge E0:
  - busy is high for cycles E0..E0+WIDTH-1, i.e. WIDTH cycles.
  - sout carries d[k] during the cycle after edge E0+k.
  - done is high during the cycle following edge E0+WIDTH.
- RX accepted at edge E0: sin is sampled at edges E0+1..E0+WIDTH. done and final q are valid after edge E0+WIDTH.
- The done cycle is IDLE, so a new command with en=1 in that cycle is accepted at the next edge. Back-to-back bursts therefore have no idle gap beyond the done cycle.
- Reset during TX or RX aborts the burst. No done pulse is produced, and q=RESET_VAL.
- A reset edge that coincides with the final burst edge also yields done=0.

## Structure
- Shared package univ_shift_pkg contains:
  - mode localparams MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR, MODE_TX, MODE_RX;
  - state encoding ST_IDLE, ST_TX, ST_RX.
- Single module, with the burst counter inline. No sub-module is warranted.
- An elaboration-time check rejects WIDTH<2.

## Test plan
All scenarios use WIDTH=7 and RESET_VAL=0.
- Reset: hold reset=1 for 2 edges with en=1, mode=001, d=1010101 -> q=0000000, busy=0, done=0, sout=0.
- Plain modes, each step en=1 for one edge:
  - load 0000111 -> q=0000111;
  - shl with sin=1 -> 0001111;
  - shr with sin=0 -> 0000111;
  - load 1000001, then rotl -> 0000011;
  - rotr -> 1000001;
  - en=0 with mode=001 -> q unchanged.
- TX with d=1011001, mode=110:
  - sout = 1,0,0,1,1,0,1 over 7 consecutive cycles;
  - busy high for exactly 7 cycles, then done=1 for 1 cycle;
  - q=0000000;
  - a load command issued mid-burst is ignored.
- RX with mode=111, sin = 1,1,0,1,0,0,1 on successive edges -> q=1001011, done pulse once, busy for 7 cycles.
- Reset abort: assert reset during the 3rd TX cycle -> q=0, busy=0 at the next cycle, no done, sout=0.
- Back-to-back: issue TX d=1111111 in the done cycle of a prior RX -> TX starts at the next edge, and sout=1 for 7 cycles.
